lfsr_burst_scheduler: RTL and testbench

//  Shares one 8-bit XNOR LFSR (ports clk/rst/en/out) between NREQ requesters.

---
 rtl/lfsr_sched_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/lfsr_burst_scheduler.sv | 123 ++++++++++++
 tb/tb_lfsr_burst_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_sched_pkg.sv
// Shared types for the LFSR burst scheduler: FSM state encoding and LFSR width.
package lfsr_sched_pkg;

   typedef enum logic [1:0] {IDLE, SEED, RUN, RESP} sched_state_t;

   localparam int unsigned LFSR_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
module rr_arbiter #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] gnt_idx_o,
   output logic            gnt_any_o
);

   int unsigned idx;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_i) + k) % N;
         if (!gnt_any_o && req_i[idx]) begin
            gnt_any_o      = 1'b1;
            gnt_o[idx]     = 1'b1;
            gnt_idx_o      = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/lfsr_burst_scheduler.sv
// Arbitrates burst requests onto one shared LFSR, collects its output serially and
// returns each burst as a right-aligned word on a valid/ready response channel.
module lfsr_burst_scheduler
   import lfsr_sched_pkg::*;
#(
   parameter int unsigned NREQ   = 2,
   parameter int unsigned MAXLEN = LFSR_W,
   parameter int unsigned LENW   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [NREQ*LENW-1:0] req_len_i,
   input  logic [NREQ-1:0]      req_reseed_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic                 rsp_valid_o,
   output logic [1:0]           rsp_id_o,
   output logic [MAXLEN-1:0]    rsp_data_o,
   input  logic                 rsp_ready_i,
   output logic                 lfsr_en_o,
   output logic                 lfsr_rst_o,
   input  logic                 lfsr_bit_i,
   output logic                 busy_o
);

   sched_state_t      state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        id_q, id_d;
   logic [LENW-1:0]   cnt_q, cnt_d;
   logic [MAXLEN-1:0] sr_q, sr_d;

   logic [NREQ-1:0]   gnt;
   logic [1:0]        gnt_idx;
   logic              gnt_any;
   logic [LENW-1:0]   len_sel, len_clamp;
   logic              reseed_sel;

   rr_arbiter #(
      .N    (NREQ),
      .IdxW (2)
   ) u_arb (
      .req_i     (req_valid_i),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   // Mux the granted requester's fields using the one-hot grant.
   always_comb begin
      len_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) len_sel = req_len_i[i*LENW +: LENW];
      end
      len_clamp  = (len_sel > LENW'(MAXLEN)) ? LENW'(MAXLEN) : len_sel;
      reseed_sel = |(req_reseed_i & gnt);
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      req_ready_o = '0;
      rsp_valid_o = 1'b0;
      lfsr_en_o   = 1'b0;
      lfsr_rst_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rst_ni && gnt_any) begin
               req_ready_o = gnt;
               id_d        = gnt_idx;
               cnt_d       = len_clamp;
               sr_d        = '0;
               if (reseed_sel)           state_d = SEED;
               else if (len_clamp != '0) state_d = RUN;
               else                      state_d = RESP;
            end
         end
         SEED: begin
            lfsr_en_o  = 1'b1;
            lfsr_rst_o = 1'b1;
            state_d    = (cnt_q != '0) ? RUN : RESP;
         end
         RUN: begin
            lfsr_en_o = 1'b1;
            sr_d      = {sr_q[MAXLEN-2:0], lfsr_bit_i};
            cnt_d     = cnt_q - LENW'(1);
            if (cnt_q == LENW'(1)) state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
               ptr_d   = (id_q == 2'(NREQ - 1)) ? 2'd0 : id_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end

   assign rsp_id_o   = id_q;
   assign rsp_data_o = sr_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_lfsr_burst_scheduler.sv
// Bench for lfsr_burst_scheduler: an 8-bit XNOR LFSR beside the DUT, a burst-timeline
// reference model compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_lfsr_burst_scheduler;

   localparam int NREQ = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid, req_reseed, req_ready;
   logic [7:0] req_len;
   logic       rsp_valid, rsp_ready;
   logic [1:0] rsp_id;
   logic [7:0] rsp_data;
   logic       lfsr_en, lfsr_rst, lfsr_bit, busy;
   logic [7:0] lfsr_q = 8'h00;

   always #5 clk = ~clk;

   lfsr_burst_scheduler #(
      .NREQ   (2),
      .MAXLEN (8),
      .LENW   (4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_len_i    (req_len),
      .req_reseed_i (req_reseed),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_id_o     (rsp_id),
      .rsp_data_o   (rsp_data),
      .rsp_ready_i  (rsp_ready),
      .lfsr_en_o    (lfsr_en),
      .lfsr_rst_o   (lfsr_rst),
      .lfsr_bit_i   (lfsr_bit),
      .busy_o       (busy)
   );

   // The shared LFSR: shift left, XNOR feedback of bits 7 and 6, output is bit 0.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], ~(v[7] ^ v[6])};
   endfunction

   always @(posedge clk) begin
      if (lfsr_en) lfsr_q <= lfsr_rst ? 8'h00 : lfsr_step(lfsr_q);
   end
   assign lfsr_bit = lfsr_q[0];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Burst timeline model: accept cycle, length and reseed fix every later cycle's outputs.
   bit         m_valid = 0;
   bit         m_busy = 0;
   int         m_acc, m_len, m_id, m_data, m_ptr = 0;
   bit         m_reseed;
   logic [7:0] m_lfsr = 8'h00;

   int  n_acc = 0, n_rsp = 0, last_acc = 0, rv_cyc = 0, obs_data = 0, obs_id = 0;
   bit  rv_prev = 0;
   int  gnt_log[$];

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endfunction

   task automatic model_cycle();
      int         rsp_c;
      bit         in_burst, in_resp, any;
      int         g;
      logic [1:0] er;
      rsp_c    = m_acc + m_len + 1 + (m_reseed ? 1 : 0);
      in_burst = m_busy && (cyc < rsp_c);
      in_resp  = m_busy && (cyc >= rsp_c);
      er = '0; any = 0; g = 0;
      if (!m_busy && rst_n) begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (!any && req_valid[j]) begin any = 1; g = j; er[j] = 1'b1; end
         end
      end
      if (m_valid) begin
         check("req_ready", int'(req_ready), int'(er));
         check("busy", int'(busy), int'(m_busy));
         check("rsp_valid", int'(rsp_valid), int'(in_resp));
         check("lfsr_en", int'(lfsr_en), int'(in_burst));
         check("lfsr_rst", int'(lfsr_rst), int'(in_burst && m_reseed && cyc == m_acc + 1));
         if (in_resp) begin
            check("rsp_id", int'(rsp_id), m_id);
            check("rsp_data", int'(rsp_data), m_data);
         end
      end
      if (rsp_valid && !rv_prev) begin
         rv_cyc = cyc; obs_data = int'(rsp_data); obs_id = int'(rsp_id); n_rsp++;
      end
      rv_prev = rsp_valid;
      for (int k = 0; k < NREQ; k++) begin
         if (req_ready[k]) begin gnt_log.push_back(k); last_acc = cyc; n_acc++; end
      end
      if (in_burst) begin
         if (m_reseed && cyc == m_acc + 1) m_lfsr = 8'h00;
         else begin
            m_data = (m_data << 1) | int'(m_lfsr[0]);
            m_lfsr = lfsr_step(m_lfsr);
         end
      end
      if (!rst_n) begin
         m_busy = 0; m_ptr = 0; m_valid = 1;
      end else if (in_resp && rsp_ready) begin
         m_busy = 0; m_ptr = (m_id + 1) % NREQ;
      end else if (any) begin
         m_busy   = 1; m_acc = cyc; m_id = g; m_data = 0;
         m_len    = int'(req_len[g*4 +: 4]);
         if (m_len > 8) m_len = 8;
         m_reseed = req_reseed[g];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue(input int r, input int len, input bit rs);
      int a0;
      a0 = n_acc;
      req_valid[r] = 1'b1; req_len[r*4 +: 4] = len[3:0]; req_reseed[r] = rs;
      for (int i = 0; i < 20 && n_acc == a0; i++) tick();
      req_valid[r] = 1'b0; req_reseed[r] = 1'b0;
      check("accept_count", n_acc - a0, 1);
   endtask

   task automatic wait_rsp(input int r0);
      for (int i = 0; i < 40 && n_rsp == r0; i++) tick();
      check("rsp_count", n_rsp - r0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && busy; i++) tick();
   endtask

   task automatic run_req(input int r, input int len, input bit rs, output int lat,
                          output int data, output int id);
      int r0;
      r0 = n_rsp;
      issue(r, len, rs);
      wait_rsp(r0);
      lat = rv_cyc - last_acc; data = obs_data; id = obs_id;
      drain();
   endtask

   initial begin
      int lat, data, id, a0, r0;
      rst_n = 1'b0; req_valid = '0; req_reseed = '0; req_len = '0; rsp_ready = 1'b1;
      tick(); tick();
      check("reset_outputs",
            int'({req_ready, rsp_valid, rsp_id, rsp_data, lfsr_en, lfsr_rst, busy}), 0);
      rst_n = 1'b1;
      tick();

      // Reseeded full-length burst, then an unseeded continuation.
      run_req(0, 8, 1'b1, lat, data, id);
      check("t1_data", data, 8'h7F); check("t1_id", id, 0); check("t1_lat", lat, 10);
      run_req(0, 4, 1'b0, lat, data, id);
      check("t2_data", data, 8'h07); check("t2_lat", lat, 5);

      // Both requesters held: grants alternate from ptr=0.
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      a0 = gnt_log.size();
      req_len = {4'd2, 4'd2}; req_valid = 2'b11;
      for (int i = 0; i < 60 && (n_acc - a0) < 4; i++) tick();
      req_valid = '0;
      drain();
      check("t3_grants", n_acc - a0, 4);
      for (int i = 0; i < 4 && a0 + i < gnt_log.size(); i++) check("t3_order", gnt_log[a0+i], i % 2);

      // Response back-pressure holds id/data with the LFSR frozen.
      rsp_ready = 1'b0;
      r0 = n_rsp;
      issue(1, 4, 1'b1);
      wait_rsp(r0);
      for (int i = 0; i < 5; i++) tick();
      check("t4_valid", int'(rsp_valid), 1); check("t4_data", int'(rsp_data), 8'h07);
      check("t4_id", int'(rsp_id), 1);       check("t4_en", int'(lfsr_en), 0);
      rsp_ready = 1'b1;
      drain();

      // Zero length and clamped length.
      run_req(0, 0, 1'b0, lat, data, id);
      check("t5_zero_lat", lat, 1); check("t5_zero_data", data, 0);
      run_req(1, 15, 1'b0, lat, data, id);
      check("t5_clamp_lat", lat, 9);

      // Reset during the third RUN cycle abandons the burst.
      r0 = n_rsp;
      issue(0, 8, 1'b1);
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      check("t6_reset_outputs",
            int'({req_ready, rsp_valid, rsp_id, rsp_data, lfsr_en, lfsr_rst, busy}), 0);
      rst_n = 1'b1;
      tick(); tick();
      check("t6_no_rsp", n_rsp - r0, 0);
      run_req(0, 8, 1'b1, lat, data, id);
      check("t6_data", data, 8'h7F); check("t6_lat", lat, 10);

      // Random traffic, back-pressure and occasional resets against the model.
      for (int i = 0; i < 600; i++) begin
         req_valid  = 2'($urandom);
         req_len    = 8'($urandom);
         req_reseed = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         rsp_ready  = ($urandom_range(0, 2) != 0);
         rst_n      = ($urandom_range(0, 99) != 0);
         tick();
      end
      rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
      drain();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
